divider_constant_time: RTL and testbench

- Sequential unsigned restoring divider: the inverse operation of the team's constant-time shift-add multiplier.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per cycle.
- Fixed latency regardless of operand values, including divide-by-zero. This keeps timing data-independent and matches the constant-time multiplier.
- Sits beside the multiplier in the arithmetic unit and uses the same start/done handshake.

---
 rtl/arith_pkg.sv | 18 +
 rtl/divider_datapath.sv | 86 ++++++++
 rtl/divider_constant_time.sv | 84 ++++++++
 tb/tb_divider_constant_time.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit: FSM state encodings for the
// constant-time multiplier and divider, and the iteration counter sizing helper.
package arith_pkg;

    localparam logic [1:0] MUL_IDLE  = 2'd0;
    localparam logic [1:0] MUL_SHIFT = 2'd1;
    localparam logic [1:0] MUL_DONE  = 2'd2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_datapath.sv
// Restoring-division datapath: partial remainder R, quotient/dividend Q, divisor D,
// the trial subtractor with restore mux, and the registered result outputs.
module divider_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             capture,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted_r;
    logic [WIDTH:0]   trial;
    logic             keep_trial;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    // Subtract and mux run every cycle so timing never depends on the operands.
    // R stays below D after every step, so its MSB is zero; folding it into the
    // decision keeps the (unreachable) overflow case well defined.
    always_comb begin
        shifted_r  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial      = shifted_r - {1'b0, d_q};
        keep_trial = ~trial[WIDTH] | r_q[WIDTH];
        r_step     = keep_trial ? trial : shifted_r;
        q_step     = {q_q[WIDTH-2:0], keep_trial};
    end

    always_comb begin
        r_d   = r_q;
        q_d   = q_q;
        d_d   = d_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        if (load) begin
            r_d = '0;
            q_d = dividend;
            d_d = divisor;
        end else if (step) begin
            r_d = r_step;
            q_d = q_step;
        end
        if (capture) begin
            quo_d = q_step;
            rem_d = r_step[WIDTH-1:0];
            dbz_d = (d_q == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            d_q   <= d_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/divider_constant_time.sv
// Constant-time unsigned restoring divider: control FSM and step counter,
// driving divider_datapath with load/step/capture strobes.
module divider_constant_time
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             quotientDone,
    output logic             div_by_zero
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load, step, capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = ITER;
                end
            end
            ITER: begin
                step  = 1'b1;
                cnt_d = cnt_q - CNT_ONE;
                // Last step lands its result straight into the output registers.
                if (cnt_q == CNT_ONE) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign quotientDone = (state_q == DONE);

    divider_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .capture     (capture),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: tb/tb_divider_constant_time.sv
// Scoreboard bench for divider_constant_time: expected results queued at each
// accepted start, checked with latency when quotientDone pulses.
module tb_divider_constant_time;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         quotientDone;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_expected = 0;

    divider_constant_time #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder),
        .busy         (busy),
        .quotientDone (quotientDone),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.q   = (b == 0) ? {W{1'b1}} : W'(a / b);
        e.r   = (b == 0) ? a : W'(a % b);
        e.dz  = (b == 0);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (quotientDone === 1'b1) begin
                done_seen++;
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_done observed=1 expected=0 at cycle %0d", cyc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                    chk("latency", 32'(cyc - e.acc), 32'(W));
                end
            end
        end
    end

    // Drive start at a negedge; the following posedge is the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb.push_back(model(a, b, cyc));
        done_expected++;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < 40), 32'd1);
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        wait_drain(tag);
        issue(a, b);
        wait_drain(tag);
    endtask

    initial begin
        logic [W-1:0] a, b;

        rst = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(quotientDone), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 100/7, then check busy mid-flight and result hold afterwards.
        issue(8'd100, 8'd7);
        @(negedge clk);
        chk("busy_iter", 32'(busy), 32'd1);
        wait_drain("t1");
        repeat (3) @(negedge clk);
        chk("hold_quotient", 32'(quotient), 32'd14);
        chk("hold_remainder", 32'(remainder), 32'd2);

        run_div(8'd255, 8'd1, "t2a");
        run_div(8'd3, 8'd200, "t2b");
        run_div(8'd5, 8'd0, "t3");

        // Starts during ITER and DONE must be ignored.
        wait_drain("t4pre");
        issue(8'd200, 8'd9);
        dividend = 8'd50;
        divisor  = 8'd5;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_in_done", 32'(quotientDone), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_idle_after_done", 32'(busy), 32'd0);
        run_div(8'd50, 8'd5, "t4b");

        // Reset mid-operation: abort and clear, no done pulse.
        issue(8'd77, 8'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        done_expected--;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_quotient", 32'(quotient), 32'd0);
        chk("t5_remainder", 32'(remainder), 32'd0);
        chk("t5_done", 32'(quotientDone), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_stay_idle", 32'(busy), 32'd0);
        run_div(8'd77, 8'd3, "t5b");

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if (i < 4) b = '0;
            run_div(a, b, "sweep");
        end

        wait_drain("final");
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(done_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
